// File: rtl/bus_responder.sv
// bus_responder: 68000 bus-cycle responder.
//   Decodes each address-strobe cycle into a chip select, inserts per-region
//   wait states, then acknowledges with dtack_n. Unmapped cycles and ROM
//   writes are answered with berr_n when BUS_RESPONDER_BERR_TIMEOUT_EN is
//   defined; otherwise they hold (no cs, no ack) until as_n rises.
//   After reset a boot overlay maps ROM at region 0x0 for BOOT_CYCLES
//   acknowledged cycles so the CPU can fetch its reset vectors.
// Ports:
//   clk      bus clock
//   reset_n  asynchronous active-low reset
//   as_n     address strobe from CPU
//   read     1 = read cycle, 0 = write
//   fc       function code (3'b111 = CPU space, never mapped)
//   addr     byte address, only addr[23:16] decoded
//   dtack_n  data transfer acknowledge (registered)
//   berr_n   bus error (registered; tied high without the macro)
//   rom_cs_n / ram_cs_n / io_cs_n  region selects (registered)
//   overlay  1 while the boot overlay is active
module bus_responder #(
  parameter int unsigned ROM_WAIT     = 2,
  parameter int unsigned RAM_WAIT     = 0,
  parameter int unsigned IO_WAIT      = 3,
  parameter int unsigned BERR_TIMEOUT = 64,
  parameter int unsigned BOOT_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        as_n,
  input  logic        read,
  input  logic [2:0]  fc,
  input  logic [23:0] addr,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        rom_cs_n,
  output logic        ram_cs_n,
  output logic        io_cs_n,
  output logic        overlay
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_FAULT} state_t;
  typedef enum logic [1:0] {RG_NONE, RG_ROM, RG_RAM, RG_IO} region_t;

  state_t     r_state, w_nxt_state;
  logic [3:0] r_wcnt, w_nxt_wcnt;
  logic [3:0] r_boot_cnt, w_nxt_boot_cnt;
  logic       r_overlay, w_nxt_overlay;
  logic       r_mapped, w_nxt_mapped;
  logic       r_dtack_n, w_nxt_dtack_n;
  logic [2:0] r_cs_n, w_nxt_cs_n;    // {rom, ram, io}
  logic       w_to_idle;
  region_t    w_region;
  logic       w_unused_addr;

`ifdef BUS_RESPONDER_BERR_TIMEOUT_EN
  logic [7:0] r_tcnt, w_nxt_tcnt;
  logic       r_berr_n, w_nxt_berr_n;
`endif

  assign w_unused_addr = ^addr[15:0];

  // Address decode; the overlay steals region 0x0 for ROM.
  always_comb begin
    w_region = RG_NONE;
    if (fc != 3'b111) begin
      if (addr[23:20] == 4'h0)
        w_region = r_overlay ? RG_ROM : RG_RAM;
      else if (addr[23:20] == 4'hF && !addr[19])
        w_region = RG_ROM;
      else if (addr[23:16] == 8'hFF)
        w_region = RG_IO;
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_wcnt     = r_wcnt;
    w_nxt_boot_cnt = r_boot_cnt;
    w_nxt_overlay  = r_overlay;
    w_nxt_mapped   = r_mapped;
    w_nxt_dtack_n  = r_dtack_n;
    w_nxt_cs_n     = r_cs_n;
    w_to_idle      = 1'b0;
`ifdef BUS_RESPONDER_BERR_TIMEOUT_EN
    w_nxt_tcnt     = r_tcnt;
    w_nxt_berr_n   = r_berr_n;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (!as_n) begin
          // Unmapped cycles (and ROM writes without the fault path) sit in
          // WAIT with no select until the strobe goes away.
          w_nxt_state = S_WAIT;
          case (w_region)
            RG_ROM: begin
              if (read) begin
                w_nxt_cs_n   = 3'b011;
                w_nxt_wcnt   = 4'(ROM_WAIT);
                w_nxt_mapped = 1'b1;
              end else begin
`ifdef BUS_RESPONDER_BERR_TIMEOUT_EN
                w_nxt_state  = S_FAULT;
                w_nxt_berr_n = 1'b0;
`endif
              end
            end
            RG_RAM: begin
              w_nxt_cs_n   = 3'b101;
              w_nxt_wcnt   = 4'(RAM_WAIT);
              w_nxt_mapped = 1'b1;
            end
            RG_IO: begin
              w_nxt_cs_n   = 3'b110;
              w_nxt_wcnt   = 4'(IO_WAIT);
              w_nxt_mapped = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_WAIT: begin
        if (as_n) begin
          w_to_idle = 1'b1;
        end else if (r_mapped) begin
          if (r_wcnt == 4'd0) begin
            w_nxt_state   = S_ACK;
            w_nxt_dtack_n = 1'b0;
          end else begin
            w_nxt_wcnt = r_wcnt - 4'd1;
          end
        end
`ifdef BUS_RESPONDER_BERR_TIMEOUT_EN
        else begin
          if (r_tcnt == 8'(BERR_TIMEOUT - 1)) begin
            w_nxt_state  = S_FAULT;
            w_nxt_berr_n = 1'b0;
          end else if (r_tcnt != 8'hFF) begin
            w_nxt_tcnt = r_tcnt + 8'd1;
          end
        end
`endif
      end
      S_ACK: begin
        if (as_n) begin
          w_to_idle = 1'b1;
          if (r_overlay) begin
            w_nxt_boot_cnt = r_boot_cnt + 4'd1;
            if (r_boot_cnt + 4'd1 == 4'(BOOT_CYCLES))
              w_nxt_overlay = 1'b0;
          end
        end
      end
      S_FAULT: begin
        if (as_n)
          w_to_idle = 1'b1;
      end
      default: w_to_idle = 1'b1;
    endcase

    if (w_to_idle) begin
      w_nxt_state   = S_IDLE;
      w_nxt_dtack_n = 1'b1;
      w_nxt_cs_n    = 3'b111;
      w_nxt_wcnt    = 4'd0;
      w_nxt_mapped  = 1'b0;
`ifdef BUS_RESPONDER_BERR_TIMEOUT_EN
      w_nxt_tcnt    = 8'd0;
      w_nxt_berr_n  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wcnt     <= '0;
      r_boot_cnt <= '0;
      r_overlay  <= 1'b1;
      r_mapped   <= 1'b0;
      r_dtack_n  <= 1'b1;
      r_cs_n     <= '1;
`ifdef BUS_RESPONDER_BERR_TIMEOUT_EN
      r_tcnt     <= '0;
      r_berr_n   <= 1'b1;
`endif
    end else begin
      r_state    <= w_nxt_state;
      r_wcnt     <= w_nxt_wcnt;
      r_boot_cnt <= w_nxt_boot_cnt;
      r_overlay  <= w_nxt_overlay;
      r_mapped   <= w_nxt_mapped;
      r_dtack_n  <= w_nxt_dtack_n;
      r_cs_n     <= w_nxt_cs_n;
`ifdef BUS_RESPONDER_BERR_TIMEOUT_EN
      r_tcnt     <= w_nxt_tcnt;
      r_berr_n   <= w_nxt_berr_n;
`endif
    end
  end

  assign dtack_n  = r_dtack_n;
  assign rom_cs_n = r_cs_n[2];
  assign ram_cs_n = r_cs_n[1];
  assign io_cs_n  = r_cs_n[0];
  assign overlay  = r_overlay;
`ifdef BUS_RESPONDER_BERR_TIMEOUT_EN
  assign berr_n   = r_berr_n;
`else
  assign berr_n   = 1'b1;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Testbench for bus_responder: directed vector table, reset sequences and
// randomized cycles checked against a timeline model of the bus protocol.
module tb_bus_responder;

  localparam int ROM_WAIT     = 2;
  localparam int RAM_WAIT     = 0;
  localparam int IO_WAIT      = 3;
  localparam int BERR_TIMEOUT = 64;
  localparam int BOOT_CYCLES  = 4;
`ifdef BUS_RESPONDER_BERR_TIMEOUT_EN
  localparam bit BERR_EN = 1'b1;
`else
  localparam bit BERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        as_n;
  logic        read;
  logic [2:0]  fc;
  logic [23:0] addr;
  logic        dtack_n, berr_n, rom_cs_n, ram_cs_n, io_cs_n, overlay;
  logic [5:0]  w_obs;

  int n_cmp = 0;
  int n_err = 0;
  bit ovl_m = 1'b1;
  int boot_m = 0;

  always #5 clk = ~clk;

  bus_responder #(
    .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT), .IO_WAIT(IO_WAIT),
    .BERR_TIMEOUT(BERR_TIMEOUT), .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .as_n(as_n), .read(read), .fc(fc),
    .addr(addr), .dtack_n(dtack_n), .berr_n(berr_n), .rom_cs_n(rom_cs_n),
    .ram_cs_n(ram_cs_n), .io_cs_n(io_cs_n), .overlay(overlay)
  );

  assign w_obs = {dtack_n, berr_n, rom_cs_n, ram_cs_n, io_cs_n, overlay};

  // kind: 0 = acknowledged region, 1 = immediate fault (ROM write), 2 = unmapped
  typedef struct {
    logic [23:0] a;
    logic        rd;
    logic [2:0]  f;
    int          h;
    logic [2:0]  cs;
    int          w;
    int          kind;
  } vec_t;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {dtack,berr,rom,ram,io,ovl}=%b expected %b", name, act, exp);
    end
  endtask

  // Memory map as seen by the CPU, including the overlay and write protection.
  function automatic void model_decode(input logic [23:0] a, input logic rd,
                                       input logic [2:0] f, input bit ovl,
                                       output logic [2:0] cs, output int w,
                                       output int kind);
    cs = 3'b111; w = 0; kind = 2;
    if (f != 3'b111) begin
      if (a[23:20] == 4'h0) begin
        kind = 0;
        if (ovl) begin cs = 3'b011; w = ROM_WAIT; end
        else     begin cs = 3'b101; w = RAM_WAIT; end
      end else if (a[23:20] == 4'hF && !a[19]) begin
        kind = 0; cs = 3'b011; w = ROM_WAIT;
      end else if (a[23:16] == 8'hFF) begin
        kind = 0; cs = 3'b110; w = IO_WAIT;
      end
    end
    if (kind == 0 && cs == 3'b011 && !rd) begin
      kind = 1; cs = 3'b111;
    end
  endfunction

  // Called at a negedge. Strobe held low for h edges (E0..E0+h-1), then
  // released; every post-edge output state is compared with the timeline.
  task automatic run_cycle(input logic [23:0] a, input logic rd, input logic [2:0] f,
                           input int h, input logic [2:0] cs, input int w,
                           input int kind, input string name);
    logic [5:0] e;
    addr = a; read = rd; fc = f; as_n = 1'b0;
    for (int t = 0; t < h; t++) begin
      @(negedge clk);
      e = {5'b11111, ovl_m};
      if (kind == 0) begin
        e[3:1] = cs;
        if (t >= w + 1) e[5] = 1'b0;
      end else if (kind == 1) begin
        if (BERR_EN) e[4] = 1'b0;
      end else begin
        if (BERR_EN && t >= BERR_TIMEOUT) e[4] = 1'b0;
      end
      check($sformatf("%s t=%0d", name, t), w_obs, e);
    end
    as_n = 1'b1;
    // Only a cycle that reached dtack before release advances the overlay.
    if (kind == 0 && h >= w + 2 && ovl_m) begin
      boot_m++;
      if (boot_m == BOOT_CYCLES) ovl_m = 1'b0;
    end
    @(negedge clk);
    check($sformatf("%s release", name), w_obs, {5'b11111, ovl_m});
  endtask

  vec_t tbl[16];

  initial begin
    logic [7:0] tops [8];
    logic [23:0] ra;
    logic rrd;
    logic [2:0] rf, rcs;
    int rh, rw, rk;

    tops = '{8'h00, 8'h0A, 8'h50, 8'hF0, 8'hF7, 8'hF8, 8'hFF, 8'h80};

    tbl[0]  = '{24'h000100, 1'b0, 3'd5,  3, 3'b111, 0, 1};       // write to overlaid ROM
    tbl[1]  = '{24'h000000, 1'b1, 3'd6,  5, 3'b011, 2, 0};
    tbl[2]  = '{24'h000002, 1'b1, 3'd6,  5, 3'b011, 2, 0};
    tbl[3]  = '{24'h000004, 1'b1, 3'd6,  5, 3'b011, 2, 0};
    tbl[4]  = '{24'h000006, 1'b1, 3'd6,  5, 3'b011, 2, 0};       // overlay ends here
    tbl[5]  = '{24'h000000, 1'b1, 3'd5,  3, 3'b101, 0, 0};       // now RAM
    tbl[6]  = '{24'hFF0010, 1'b0, 3'd5,  6, 3'b110, 3, 0};       // I/O write
    tbl[7]  = '{24'h500000, 1'b1, 3'd5, 68, 3'b111, 0, 2};       // unmapped timeout
    tbl[8]  = '{24'hF00000, 1'b0, 3'd5,  3, 3'b111, 0, 1};       // ROM write
    tbl[9]  = '{24'hFF0000, 1'b1, 3'd5,  1, 3'b110, 3, 0};       // aborted
    tbl[10] = '{24'h000010, 1'b1, 3'd5,  2, 3'b101, 0, 0};       // RAM right after
    tbl[11] = '{24'hF70000, 1'b1, 3'd6,  4, 3'b011, 2, 0};       // top of ROM
    tbl[12] = '{24'hF80000, 1'b1, 3'd6,  3, 3'b111, 0, 2};       // addr[19]=1 hole
    tbl[13] = '{24'h000000, 1'b1, 3'd7,  3, 3'b111, 0, 2};       // IACK space
    tbl[14] = '{24'h0FFFFE, 1'b0, 3'd5,  2, 3'b101, 0, 0};       // RAM write
    tbl[15] = '{24'hF00000, 1'b1, 3'd6,  3, 3'b011, 2, 0};       // released on ack edge

    reset_n = 1'b0; as_n = 1'b1; read = 1'b1; fc = 3'd6; addr = '0;
    @(negedge clk);
    as_n = 1'b0;
    @(negedge clk);
    check("reset hold", w_obs, 6'b111111);
    as_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset idle", w_obs, 6'b111111);

    for (int i = 0; i < 16; i++)
      run_cycle(tbl[i].a, tbl[i].rd, tbl[i].f, tbl[i].h, tbl[i].cs,
                tbl[i].w, tbl[i].kind, $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a ROM wait, overlay already off.
    addr = 24'hF00000; read = 1'b1; fc = 3'd6; as_n = 1'b0;
    @(negedge clk);
    check("midwait cs", w_obs, {5'b11011, ovl_m});
    @(negedge clk);
    check("midwait hold", w_obs, {5'b11011, ovl_m});
    #1 reset_n = 1'b0;
    #1 check("async reset", w_obs, 6'b111111);
    ovl_m = 1'b1; boot_m = 0;
    @(negedge clk);
    as_n = 1'b1; reset_n = 1'b1;
    @(negedge clk);
    check("post reset idle", w_obs, 6'b111111);

    for (int i = 0; i < 300; i++) begin
      ra  = {tops[$urandom_range(0, 7)], 16'($urandom)};
      if ($urandom_range(0, 7) == 0) ra[23:16] = 8'($urandom);
      rrd = 1'($urandom_range(0, 1));
      rf  = 3'($urandom_range(0, 7));
      rh  = ($urandom_range(0, 19) == 0) ? 66 : $urandom_range(1, 8);
      model_decode(ra, rrd, rf, ovl_m, rcs, rw, rk);
      run_cycle(ra, rrd, rf, rh, rcs, rw, rk, $sformatf("rnd%0d a=%h", i, ra));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
